audio_gain_stage: RTL
=====================

# audio_gain_stage

Per-channel digital volume stage between the I2S receive and transmit paths. It consumes the parallel left/right 24-bit samples and the one-cycle new-sample strobe produced by the I2S data interface. It applies a zipper-free, ramped gain with mute and saturation, then presents the processed pair for the I2S transmit path to load on the next frame. A single multiplier is time-shared across both channels by a small FSM.

## Interface

- DATA_W, 24, sample width (two's complement)
- GAIN_W, 8, gain width; unsigned Q1.7, 128 = unity, 255 ≈ 1.992
- RAMP_STEP, 4, maximum gain change per sample, in LSBs

Ports:
- clk  in  1  system clock, the same clock that drives the I2S data interface
- rst  in  1  synchronous, active-high reset
- audio_l_in  in  DATA_W  left sample from the I2S receive path
- audio_r_in  in  DATA_W  right sample from the I2S receive path
- new_sample  in  1  one-cycle strobe; samples are valid in that cycle
- gain_l  in  GAIN_W  left target gain
- gain_r  in  GAIN_W  right target gain
- mute  in  1  forces both target gains to 0
- audio_l_out  out  DATA_W  processed left sample, held between updates
- audio_r_out  out  DATA_W  processed right sample, held between updates
- out_valid  out  1  one-cycle pulse when the outputs update
- clip_l  out  1  pulses with out_valid when the left result saturated
- clip_r  out  1  pulses with out_valid when the right result saturated
- overrun  out  1  sticky; set when new_sample arrives while the block is not IDLE

## Operation

- FSM states: IDLE, RAMP, MUL_L, MUL_R, DONE.
- IDLE:
  - When new_sample = 1, latch audio_l_in and audio_r_in, then go to RAMP.
  - Otherwise stay in IDLE.
- RAMP:
  - Targets: tgt_x = mute ? 0 : gain_x, sampled in this cycle.
  - If cur_x < tgt_x: cur_x = min(cur_x + RAMP_STEP, tgt_x).
  - If cur_x > tgt_x: cur_x = max(cur_x − RAMP_STEP, tgt_x).
  - If cur_x = tgt_x: cur_x is unchanged.
  - Compute with a GAIN_W+1-bit intermediate so that no wrap occurs at 0 or 255.
  - Go to MUL_L.
- MUL_L: shared multiplier computes the left channel result into res_l and clip flag cl_l. Go to MUL_R.
- MUL_R: same computation for the right channel into res_r and cl_r. Go to DONE.
- DONE: load the outputs from res_l/res_r, pulse out_valid, drive clip_l/clip_r from cl_l/cl_r, return to IDLE.
- Multiply and saturate rule:
  - Product p = sample (signed, DATA_W) × {0, cur} (signed, GAIN_W+1), width DATA_W+GAIN_W+1.
  - Shift p arithmetically right by 7 (truncation toward −∞).
  - Saturate the shifted value to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - The clip flag is set when saturation changed the value.
- Gain updates happen only once per accepted sample, never between samples.
- new_sample outside IDLE: the strobe is ignored, the sample in flight completes unchanged, and overrun is set to 1. Only rst clears overrun.
- mute takes effect through the ramp. It is never an instant cut.
- Reset values: state IDLE, cur_l = cur_r = 0 (power-up fades in), audio_l_out = audio_r_out = 0, out_valid = clip_l = clip_r = overrun = 0.
- Reset mid-operation: any in-flight sample is discarded, no out_valid is produced, and the outputs go to 0.

## Timing

- new_sample high in cycle N (block IDLE) → RAMP in N+1, MUL_L in N+2, MUL_R in N+3, DONE in N+4.
- Outputs change, and out_valid/clip_x are high, in cycle N+5 for exactly one cycle. Latency is 5 clocks.
- Minimum spacing between accepted strobes is 5 clocks. A strobe in cycle N+5 is accepted because the block is back in IDLE.
- Outputs hold their value between out_valid pulses.
- One sample period of audio (≥2000 clocks at 100 MHz / 48 kHz) is far longer than the latency. The processed pair is therefore stable before the transmit path's next frame load.
- Gain inputs are sampled only in the RAMP cycle. They need not be stable at any other time.

## Test plan

- Reset, gain_l = gain_r = 128, RAMP_STEP = 4, then 32 strobes with L = 0x100000, R = 0xF00000:
  - Gain ramps 4, 8, …, 128, so outputs before the 32nd strobe are below input magnitude.
  - The 32nd strobe gives out_valid five cycles later with L = 0x100000, R = 0xF00000 and no clip.
- Settled gain 255:
  - L = 0x7FFFFF gives 0x7FFFFF with clip_l = 1.
  - R = 0x800000 gives 0x800000 with clip_r = 1.
  - L = 0x000100 gives 0x0001FE with no clip.
- Settled gain_l = 64 with L = 0x100000 gives 0x080000. Settled gain_l = 64 with L = 0xFFFFFF (−1) gives 0xFFFFFF (−1 floor).
- At unity gain, assert mute: cur steps down 4 per sample. After 32 samples both outputs are 0. Deassert mute: gain ramps back up.
- Strobe, then a second strobe 2 cycles later:
  - Exactly one out_valid at N+5 carrying the first sample.
  - overrun = 1 and stays 1 until rst.
- Strobe in N, assert rst in N+2 for one cycle:
  - No out_valid.
  - audio_x_out = 0, cur gains = 0, state IDLE.
  - The next strobe is processed normally.

Source files
------------

// File: rtl/audio_gain_stage_if.sv
// Sample/gain bus between the I2S data interface and the gain stage.
// master drives samples and gains; slave is the gain stage itself.
interface audio_gain_stage_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned GAIN_W = 8
);
  logic [DATA_W-1:0] audio_l_in;
  logic [DATA_W-1:0] audio_r_in;
  logic              new_sample;
  logic [GAIN_W-1:0] gain_l;
  logic [GAIN_W-1:0] gain_r;
  logic              mute;
  logic [DATA_W-1:0] audio_l_out;
  logic [DATA_W-1:0] audio_r_out;
  logic              out_valid;
  logic              clip_l;
  logic              clip_r;
  logic              overrun;

  modport master (
    output audio_l_in, audio_r_in, new_sample, gain_l, gain_r, mute,
    input  audio_l_out, audio_r_out, out_valid, clip_l, clip_r, overrun
  );

  modport slave (
    input  audio_l_in, audio_r_in, new_sample, gain_l, gain_r, mute,
    output audio_l_out, audio_r_out, out_valid, clip_l, clip_r, overrun
  );
endinterface

// File: rtl/audio_gain_stage.sv
// Ramped stereo gain stage with mute and saturation; one multiplier is
// time-shared between the left and right channels by a five-state FSM.
module audio_gain_stage #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned RAMP_STEP = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  audio_gain_stage_if.slave io_agc
);

  localparam int unsigned ProdW = DATA_W + GAIN_W + 1;
  localparam int unsigned FracW = GAIN_W - 1;

  typedef enum logic [2:0] {StIdle, StRamp, StMulL, StMulR, StDone} state_e;

  state_e r_state, w_state_d;

  logic [DATA_W-1:0] r_smp_l, r_smp_r;
  logic [GAIN_W-1:0] r_cur_l, r_cur_r;
  logic [DATA_W-1:0] r_res_l, r_res_r;
  logic              r_cl_l, r_cl_r;
  logic [DATA_W-1:0] r_out_l, r_out_r;
  logic              r_out_valid, r_clip_l, r_clip_r, r_overrun;

  logic [GAIN_W-1:0]       w_tgt_l, w_tgt_r;
  logic signed [ProdW-1:0] w_mul_a, w_mul_b, w_prod, w_shift;
  logic [ProdW-DATA_W:0]   w_hi;
  logic                    w_ovf;
  logic [DATA_W-1:0]       w_sat;

  // Move cur toward tgt by at most RAMP_STEP; the extra bit keeps 0 and 255 from wrapping.
  function automatic logic [GAIN_W-1:0] ramp_gain(input logic [GAIN_W-1:0] cur,
                                                  input logic [GAIN_W-1:0] tgt);
    logic [GAIN_W:0]   cur_x, tgt_x, step_x;
    logic [GAIN_W-1:0] res;
    cur_x  = {1'b0, cur};
    tgt_x  = {1'b0, tgt};
    step_x = (GAIN_W+1)'(RAMP_STEP);
    res    = cur;
    if (cur_x < tgt_x) begin
      res = (cur_x + step_x >= tgt_x) ? tgt : cur + GAIN_W'(RAMP_STEP);
    end else if (cur_x > tgt_x) begin
      res = (cur_x >= tgt_x + step_x) ? cur - GAIN_W'(RAMP_STEP) : tgt;
    end
    return res;
  endfunction

  assign w_tgt_l = io_agc.mute ? '0 : io_agc.gain_l;
  assign w_tgt_r = io_agc.mute ? '0 : io_agc.gain_r;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (io_agc.new_sample) w_state_d = StRamp;
      StRamp:  w_state_d = StMulL;
      StMulL:  w_state_d = StMulR;
      StMulR:  w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Shared multiplier: sample sign-extended, gain zero-extended (Q1.7 is unsigned).
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    if (r_state == StMulR) begin
      w_mul_a = {{(ProdW-DATA_W){r_smp_r[DATA_W-1]}}, r_smp_r};
      w_mul_b = {{(ProdW-GAIN_W){1'b0}}, r_cur_r};
    end else begin
      w_mul_a = {{(ProdW-DATA_W){r_smp_l[DATA_W-1]}}, r_smp_l};
      w_mul_b = {{(ProdW-GAIN_W){1'b0}}, r_cur_l};
    end
  end

  assign w_prod  = w_mul_a * w_mul_b;
  assign w_shift = w_prod >>> FracW;
  // Result fits only if every bit above the output sign bit matches it.
  assign w_hi    = w_shift[ProdW-1:DATA_W-1];
  assign w_ovf   = !((&w_hi) || !(|w_hi));
  assign w_sat   = !w_ovf ? w_shift[DATA_W-1:0] :
                   w_shift[ProdW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_smp_l     <= '0;
      r_smp_r     <= '0;
      r_cur_l     <= '0;
      r_cur_r     <= '0;
      r_res_l     <= '0;
      r_res_r     <= '0;
      r_cl_l      <= 1'b0;
      r_cl_r      <= 1'b0;
      r_out_l     <= '0;
      r_out_r     <= '0;
      r_out_valid <= 1'b0;
      r_clip_l    <= 1'b0;
      r_clip_r    <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_out_valid <= 1'b0;
      r_clip_l    <= 1'b0;
      r_clip_r    <= 1'b0;
      if (r_state != StIdle && io_agc.new_sample) r_overrun <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (io_agc.new_sample) begin
            r_smp_l <= io_agc.audio_l_in;
            r_smp_r <= io_agc.audio_r_in;
          end
        end
        StRamp: begin
          r_cur_l <= ramp_gain(r_cur_l, w_tgt_l);
          r_cur_r <= ramp_gain(r_cur_r, w_tgt_r);
        end
        StMulL: begin
          r_res_l <= w_sat;
          r_cl_l  <= w_ovf;
        end
        StMulR: begin
          r_res_r <= w_sat;
          r_cl_r  <= w_ovf;
        end
        StDone: begin
          r_out_l     <= r_res_l;
          r_out_r     <= r_res_r;
          r_out_valid <= 1'b1;
          r_clip_l    <= r_cl_l;
          r_clip_r    <= r_cl_r;
        end
        default: ;
      endcase
    end
  end

  assign io_agc.audio_l_out = r_out_l;
  assign io_agc.audio_r_out = r_out_r;
  assign io_agc.out_valid   = r_out_valid;
  assign io_agc.clip_l      = r_clip_l;
  assign io_agc.clip_r      = r_clip_r;
  assign io_agc.overrun     = r_overrun;

endmodule
